// File: rtl/diff_stats_pkg.sv
// Shared types and constants for the window statistics block.
package diff_stats_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Sample limits for the default 5-bit signed difference.
  localparam int DIFF_W_DEF = 5;
  localparam logic signed [DIFF_W_DEF-1:0] DIFF_MAX = 5'sd15;
  localparam logic signed [DIFF_W_DEF-1:0] DIFF_MIN = -5'sd16;

  localparam int ACC_W_DEF = 10;

  // Saturating add at the default accumulator width; returns {sat_flag, result}.
  function automatic logic [ACC_W_DEF:0] sat_add(input logic [ACC_W_DEF-1:0] acc,
                                                 input logic [ACC_W_DEF-1:0] sext_diff);
    logic [ACC_W_DEF:0] full;
    full = {acc[ACC_W_DEF-1], acc} + {sext_diff[ACC_W_DEF-1], sext_diff};
    if (full[ACC_W_DEF] != full[ACC_W_DEF-1]) begin
      return {1'b1, full[ACC_W_DEF], {(ACC_W_DEF-1){~full[ACC_W_DEF]}}};
    end
    return {1'b0, full[ACC_W_DEF-1:0]};
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational W-bit two's complement adder clamping to the representable range.
module sat_add_signed #(
  parameter int W = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         sat_o
);

  logic [W:0] full;

  // One extra bit catches overflow; its sign selects the clamp direction.
  always_comb begin
    full = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    sat_o = (full[W] != full[W-1]);
    if (sat_o) begin
      sum_o = {full[W], {(W-1){~full[W]}}};
    end else begin
      sum_o = full[W-1:0];
    end
  end

endmodule

// File: rtl/diff_window_accum.sv
// Collects WIN_LEN signed differences and presents sum/min/max/negative-count
// for each window, held until the downstream consumer takes it.
module diff_window_accum
  import diff_stats_pkg::*;
#(
  parameter int DIFF_W  = 5,
  parameter int ACC_W   = 10,
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIFF_W-1:0] in_diff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DIFF_W-1:0] out_min,
  output logic [DIFF_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_neg_cnt,
  output logic              out_ovf
);

  state_t state_q, state_d;

  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [CNT_W-1:0]  neg_q, neg_d;
  logic        [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DIFF_W-1:0] min_q, min_d;
  logic signed [DIFF_W-1:0] max_q, max_d;
  logic                     ovf_q, ovf_d;

  logic [ACC_W-1:0]  osum_q, osum_d;
  logic [DIFF_W-1:0] omin_q, omin_d;
  logic [DIFF_W-1:0] omax_q, omax_d;
  logic [CNT_W-1:0]  oneg_q, oneg_d;
  logic              oovf_q, oovf_d;

  logic signed [DIFF_W-1:0] diff_s;
  logic        [ACC_W-1:0]  diff_sext;
  logic        [ACC_W-1:0]  acc_sum;
  logic                     acc_sat;
  logic signed [DIFF_W-1:0] min_nxt, max_nxt;
  logic        [CNT_W-1:0]  neg_nxt;
  logic                     first, last;

  assign diff_s    = $signed(in_diff);
  assign diff_sext = {{(ACC_W-DIFF_W){in_diff[DIFF_W-1]}}, in_diff};

  sat_add_signed #(.W(ACC_W)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (diff_sext),
    .sum_o (acc_sum),
    .sat_o (acc_sat)
  );

  // Per-sample statistic candidates; the first sample of a window seeds min/max.
  always_comb begin
    first   = (cnt_q == '0);
    last    = (cnt_q == CNT_W'(WIN_LEN - 1));
    min_nxt = (first || diff_s < min_q) ? diff_s : min_q;
    max_nxt = (first || diff_s > max_q) ? diff_s : max_q;
    neg_nxt = neg_q + CNT_W'(in_diff[DIFF_W-1]);
  end

  // Next-state logic: clr outranks accept/take and leaves the published result alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    min_d   = min_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    osum_d  = osum_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    oneg_d  = oneg_q;
    oovf_d  = oovf_q;
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);

    if (clr) begin
      state_d = ACCUM;
      cnt_d   = '0;
      neg_d   = '0;
      acc_d   = '0;
      min_d   = '0;
      max_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (last) begin
              osum_d  = acc_sum;
              omin_d  = min_nxt;
              omax_d  = max_nxt;
              oneg_d  = neg_nxt;
              oovf_d  = ovf_q | acc_sat;
              cnt_d   = '0;
              neg_d   = '0;
              acc_d   = '0;
              min_d   = '0;
              max_d   = '0;
              ovf_d   = 1'b0;
              state_d = HOLD;
            end else begin
              acc_d = acc_sum;
              ovf_d = ovf_q | acc_sat;
              min_d = min_nxt;
              max_d = max_nxt;
              neg_d = neg_nxt;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      neg_q   <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
      osum_q  <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      oneg_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      min_q   <= min_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
      osum_q  <= osum_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      oneg_q  <= oneg_d;
      oovf_q  <= oovf_d;
    end
  end

  assign out_sum     = osum_q;
  assign out_min     = omin_q;
  assign out_max     = omax_q;
  assign out_neg_cnt = oneg_q;
  assign out_ovf     = oovf_q;

endmodule

// File: tb/tb_diff_window_accum.sv
// Directed bench: a default-width instance (A) and a narrow ACC_W=6 instance (B).
module tb_diff_window_accum;

  logic clk = 1'b0;
  logic rst_n, clr, in_valid, out_ready;
  logic [4:0] in_diff;
  int sel;

  logic       a_in_ready, a_out_valid, a_ovf;
  logic [9:0] a_sum;
  logic [4:0] a_min, a_max;
  logic [3:0] a_neg;
  logic       b_in_ready, b_out_valid, b_ovf;
  logic [5:0] b_sum;
  logic [4:0] b_min, b_max;
  logic [3:0] b_neg;

  logic       m_in_ready, m_out_valid, m_ovf;
  logic [9:0] m_sum;
  logic [4:0] m_min, m_max;
  logic [3:0] m_neg;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  diff_window_accum u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr & (sel == 0)),
    .in_valid(in_valid & (sel == 0)), .in_ready(a_in_ready), .in_diff(in_diff),
    .out_valid(a_out_valid), .out_ready(out_ready & (sel == 0)),
    .out_sum(a_sum), .out_min(a_min), .out_max(a_max),
    .out_neg_cnt(a_neg), .out_ovf(a_ovf)
  );

  diff_window_accum #(.ACC_W(6)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr & (sel == 1)),
    .in_valid(in_valid & (sel == 1)), .in_ready(b_in_ready), .in_diff(in_diff),
    .out_valid(b_out_valid), .out_ready(out_ready & (sel == 1)),
    .out_sum(b_sum), .out_min(b_min), .out_max(b_max),
    .out_neg_cnt(b_neg), .out_ovf(b_ovf)
  );

  always_comb begin
    if (sel == 1) begin
      m_in_ready = b_in_ready; m_out_valid = b_out_valid; m_ovf = b_ovf;
      m_sum = {{4{b_sum[5]}}, b_sum}; m_min = b_min; m_max = b_max; m_neg = b_neg;
    end else begin
      m_in_ready = a_in_ready; m_out_valid = a_out_valid; m_ovf = a_ovf;
      m_sum = a_sum; m_min = a_min; m_max = a_max; m_neg = a_neg;
    end
  end

  typedef struct {
    string name;
    int    sel;
    int    d [8];
    int    sum;
    int    mn;
    int    mx;
    int    neg;
    int    ovf;
  } win_t;

  win_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offers eight samples back to back, then checks the result one cycle later.
  task automatic run_window(input win_t w);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check({w.name, " in_ready"}, int'(m_in_ready), 1);
      check({w.name, " early out_valid"}, int'(m_out_valid), 0);
      in_valid = 1'b1;
      in_diff  = 5'(w.d[k]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({w.name, " out_valid"}, int'(m_out_valid), 1);
    check({w.name, " sum"}, int'($signed(m_sum)), w.sum);
    check({w.name, " min"}, int'($signed(m_min)), w.mn);
    check({w.name, " max"}, int'($signed(m_max)), w.mx);
    check({w.name, " neg_cnt"}, int'(m_neg), w.neg);
    check({w.name, " ovf"}, int'(m_ovf), w.ovf);
  endtask

  task automatic take(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " take out_valid"}, int'(m_out_valid), 0);
    check({name, " take in_ready"}, int'(m_in_ready), 1);
  endtask

  int held;

  initial begin
    tbl[0] = '{"w_plus3", 0, '{3, 3, 3, 3, 3, 3, 3, 3}, 24, 3, 3, 0, 0};
    tbl[1] = '{"w_alt", 0, '{1, -2, 3, -4, 5, -6, 7, -8}, -4, -8, 7, 4, 0};
    tbl[2] = '{"w_min15", 0, '{-15, -15, -15, -15, -15, -15, -15, -15}, -120, -15, -15, 8, 0};
    tbl[3] = '{"w_mixed", 0, '{0, 15, -16, 2, 0, -1, 9, 4}, 13, -16, 15, 2, 0};
    tbl[4] = '{"w_sat6", 1, '{15, 15, 15, 15, 15, 15, 15, 15}, 31, 15, 15, 0, 1};
    tbl[5] = '{"w_after_sat6", 1, '{1, 1, 1, 1, 1, 1, 1, 1}, 8, 1, 1, 0, 0};

    sel = 0; rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_diff = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset out_valid", int'(a_out_valid), 0);
    check("reset in_ready", int'(a_in_ready), 1);
    check("reset sum", int'(a_sum), 0);
    check("reset min/max", int'({a_min, a_max}), 0);
    check("reset neg/ovf", int'({a_neg, a_ovf}), 0);

    for (int i = 0; i < 6; i++) begin
      sel = tbl[i].sel;
      run_window(tbl[i]);
      take(tbl[i].name);
    end
    sel = 0;

    // Held result ignores offered samples while out_ready stays low.
    run_window(tbl[1]);
    held = int'(a_sum);
    in_valid = 1'b1; in_diff = 5'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold in_ready", int'(a_in_ready), 0);
      check("hold out_valid", int'(a_out_valid), 1);
      check("hold sum stable", int'(a_sum), held);
      check("hold min/max stable", int'({a_min, a_max}), int'({5'b11000, 5'd7}));
    end
    in_valid = 1'b0;
    take("hold");
    check("after take sum kept", int'(a_sum), held);

    // clr discards a partial window and the sample offered alongside it.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_diff = 5'd5;
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    run_window('{"w_clr_minus1", 0, '{-1, -1, -1, -1, -1, -1, -1, -1}, -8, -1, -1, 8, 0});

    // clr while holding drops out_valid but keeps the published data.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr hold out_valid", int'(a_out_valid), 0);
    check("clr hold in_ready", int'(a_in_ready), 1);
    check("clr hold sum kept", int'($signed(a_sum)), -8);

    // Synchronous reset while holding returns everything to zero.
    run_window(tbl[0]);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst hold out_valid", int'(a_out_valid), 0);
    check("rst hold sum", int'(a_sum), 0);
    check("rst hold min/max", int'({a_min, a_max}), 0);
    check("rst hold neg/ovf", int'({a_neg, a_ovf}), 0);
    check("rst hold in_ready", int'(a_in_ready), 1);
    @(negedge clk);
    check("rst release in_ready", int'(a_in_ready), 1);
    run_window(tbl[1]);
    take("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
